// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  localparam int DIV_W = 4;

  typedef enum logic {
    IDLE,
    CALC
  } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// start/rdy request bus of the divider, shared with the shift-add multiplier.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int W = DIV_W
);

  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         rdy;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  rdy, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output rdy, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_step.sv
// One combinational restoring-division step: shift in a dividend bit, try to subtract.
module div_step #(
  parameter int W = 4
) (
  input  logic [W:0]   i_pr,
  input  logic         i_dq_msb,
  input  logic [W-1:0] i_dvs,
  output logic [W:0]   o_pr,
  output logic         o_qbit
);

  logic [W+1:0] w_t;
  logic [W+1:0] w_d;

  // pr always stays below dvs, so its top bit is 0 and the shift needs no truncation.
  assign w_t    = {i_pr, i_dq_msb};
  assign w_d    = w_t - {2'b00, i_dvs};
  assign o_qbit = ~w_d[W+1];
  assign o_pr   = o_qbit ? w_d[W:0] : w_t[W:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, W-cycle latency, start/rdy handshake.
module seq_divider
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input logic          clk,
  input logic          reset_l,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  div_state_t    r_state;
  div_state_t    w_next_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_dq;
  logic [W-1:0]  r_dvs;
  logic [W:0]    r_pr;
  logic [W-1:0]  r_quotient;
  logic [W-1:0]  r_remainder;
  logic          r_div_by_zero;

  logic [W:0]    w_next_pr;
  logic [W-1:0]  w_next_dq;
  logic          w_qbit;
  logic          w_accept;
  logic          w_done;
  logic          w_rdy;

  div_step #(.W(W)) u_step (
    .i_pr     (r_pr),
    .i_dq_msb (r_dq[W-1]),
    .i_dvs    (r_dvs),
    .o_pr     (w_next_pr),
    .o_qbit   (w_qbit)
  );

  assign w_next_dq = {r_dq[W-2:0], w_qbit};
  assign w_done    = (r_cnt == CW'(1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_rdy        = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        w_rdy = 1'b1;
        if (bus.start) begin
          w_accept     = 1'b1;
          w_next_state = CALC;
        end
      end
      CALC:    if (w_done) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_cnt         <= '0;
      r_dq          <= '0;
      r_dvs         <= '0;
      r_pr          <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_dq  <= bus.dividend;
      r_dvs <= bus.divisor;
      r_pr  <= '0;
      r_cnt <= CW'(W);
    end else if (r_state == CALC) begin
      r_dq  <= w_next_dq;
      r_pr  <= w_next_pr;
      r_cnt <= r_cnt - CW'(1);
      // Results are published only here, so a reset mid-operation never exposes a partial value.
      if (w_done) begin
        r_quotient    <= w_next_dq;
        r_remainder   <= w_next_pr[W-1:0];
        r_div_by_zero <= (r_dvs == '0);
      end
    end
  end

  assign bus.rdy         = w_rdy;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: issued requests push expected results, a monitor checks completions.
module tb_seq_divider;
  import div_pkg::*;

  localparam int W = DIV_W;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  seq_divider_if #(.W(W)) bus ();

  seq_divider #(.W(W)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned division; a zero divisor yields all-ones / dividend.
  function automatic exp_t model(input int a, input int b, input int acc);
    exp_t e;
    if (b == 0) begin
      e.q  = '1;
      e.r  = W'(a);
      e.dz = 1'b1;
    end else begin
      e.q  = W'(a / b);
      e.r  = W'(a % b);
      e.dz = 1'b0;
    end
    e.acc = acc;
    return e;
  endfunction

  task automatic wait_rdy();
    int n = 0;
    @(negedge clk);
    while (!bus.rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rdy) check("rdy_timeout", 32'(bus.rdy), 32'd1);
  endtask

  task automatic issue(input int a, input int b, input bit push);
    wait_rdy();
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("rdy_fall", 32'(bus.rdy), 32'd0);
    if (push) sb_q.push_back(model(a, b, cyc));
  endtask

  // Monitor: a rising rdy marks a completion; compare it with the oldest expectation.
  initial begin
    logic prev_rdy = 1'b1;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_l) begin
        prev_rdy = 1'b1;
      end else begin
        if (bus.rdy && !prev_rdy) begin
          if (sb_q.size() == 0) begin
            check("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check("quotient", 32'(bus.quotient), 32'(e.q));
            check("remainder", 32'(bus.remainder), 32'(e.r));
            check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
            check("latency", 32'(cyc - e.acc), 32'(W));
          end
        end
        prev_rdy = bus.rdy;
      end
    end
  end

  initial begin
    int prev_acc;
    int n;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    #12;
    check("reset_rdy", 32'(bus.rdy), 32'd1);
    check("reset_quotient", 32'(bus.quotient), 32'd0);
    check("reset_remainder", 32'(bus.remainder), 32'd0);
    check("reset_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    #2 reset_l = 1'b1;

    issue(15, 4, 1);
    issue(7, 0, 1);
    issue(0, 5, 1);
    issue(15, 1, 1);
    issue(3, 9, 1);
    issue(15, 15, 1);

    // Busy: start and operand changes during CALC must be ignored.
    issue(9, 2, 1);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = W'($urandom_range(0, 15));
    bus.divisor  = W'($urandom_range(0, 15));
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = W'($urandom_range(0, 15));
    wait_rdy();
    repeat (W + 2) @(negedge clk);
    check("no_extra_op", 32'(bus.rdy), 32'd1);

    // Reset two edges into 13/3: outputs clear without a clock edge.
    issue(13, 3, 0);
    @(posedge clk);
    #1;
    reset_l = 1'b0;
    #1;
    check("abort_rdy", 32'(bus.rdy), 32'd1);
    check("abort_quotient", 32'(bus.quotient), 32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    bus.dividend = W'(13);
    bus.divisor  = W'(3);
    bus.start    = 1'b1;
    @(negedge clk);
    #2 reset_l = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("accept_after_reset", 32'(bus.rdy), 32'd0);
    sb_q.push_back(model(13, 3, cyc));

    // start held high: one accept every W+1 cycles.
    prev_acc = 0;
    for (int i = 0; i < 3; i++) begin
      int a = $urandom_range(0, 15);
      int b = $urandom_range(0, 15);
      wait_rdy();
      bus.dividend = W'(a);
      bus.divisor  = W'(b);
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      if (i > 0) check("accept_interval", 32'(cyc - prev_acc), 32'(W + 1));
      prev_acc = cyc;
      sb_q.push_back(model(a, b, cyc));
      bus.dividend = W'($urandom_range(0, 15));
    end
    bus.start = 1'b0;

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        issue(a, b, 1);
      end
    end

    for (int i = 0; i < 30; i++) issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1);

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
